// File: rtl/vga_pixel_pipe_pkg.sv
// Shared widths and mode encodings for the VGA pixel pipeline.
package vga_pixel_pipe_pkg;

  localparam int unsigned ColorWidthDef  = 4;
  localparam int unsigned RezMaxWidthDef = 11;

  typedef enum logic [1:0] {
    ModePass   = 2'd0,
    ModeBorder = 2'd1,
    ModeBars   = 2'd2,
    ModeCheck  = 2'd3
  } mode_e;

endpackage

// File: rtl/vga_pixel_pipe_if.sv
// Pixel request channel between the pipeline (master) and the frame source (slave).
interface vga_pixel_pipe_if #(
  parameter int unsigned COLOR_WIDTH = vga_pixel_pipe_pkg::ColorWidthDef
) ();

  logic                     data_req;
  logic [3*COLOR_WIDTH-1:0] data;
  logic                     data_valid;

  modport master (output data_req, input data, input data_valid);
  modport slave  (input data_req, output data, output data_valid);

endinterface

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern colour from display-relative coordinates.
module vga_pattern_gen
  import vga_pixel_pipe_pkg::*;
#(
  parameter int unsigned COLOR_WIDTH   = ColorWidthDef,
  parameter int unsigned REZ_MAX_WIDTH = RezMaxWidthDef,
  parameter int unsigned BAR_SHIFT     = 6,
  parameter int unsigned CHK_SHIFT     = 5
) (
  input  logic [REZ_MAX_WIDTH-1:0] xr_i,
  input  logic [REZ_MAX_WIDTH-1:0] yr_i,
  input  mode_e                    mode_i,
  output logic [3*COLOR_WIDTH-1:0] color_o
);

  logic [2:0] bar_idx;
  logic       chk;

  // Eight bars repeat every 8 << BAR_SHIFT pixels.
  assign bar_idx = 3'(xr_i >> BAR_SHIFT);
  assign chk     = 1'(xr_i >> CHK_SHIFT) ^ 1'(yr_i >> CHK_SHIFT);

  always_comb begin
    color_o = '0;
    unique case (mode_i)
      ModeBars: color_o = {{COLOR_WIDTH{bar_idx[2]}},
                           {COLOR_WIDTH{bar_idx[1]}},
                           {COLOR_WIDTH{bar_idx[0]}}};
      ModeCheck: color_o = {(3*COLOR_WIDTH){chk}};
      default:   color_o = '0;
    endcase
  end

endmodule

// File: rtl/vga_pixel_pipe.sv
// Two-stage pixel pipeline: region decode and source request, then RGB selection.
module vga_pixel_pipe
  import vga_pixel_pipe_pkg::*;
#(
  parameter int unsigned COLOR_WIDTH   = ColorWidthDef,
  parameter int unsigned REZ_MAX_WIDTH = RezMaxWidthDef,
  parameter int unsigned BAR_SHIFT     = 6,
  parameter int unsigned CHK_SHIFT     = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic [REZ_MAX_WIDTH-1:0] count_h_i,
  input  logic [REZ_MAX_WIDTH-1:0] count_v_i,
  input  logic [REZ_MAX_WIDTH-1:0] h_left_margin_i,
  input  logic [REZ_MAX_WIDTH-1:0] h_right_margin_i,
  input  logic [REZ_MAX_WIDTH-1:0] v_left_margin_i,
  input  logic [REZ_MAX_WIDTH-1:0] v_right_margin_i,
  input  logic [1:0]               mode_i,
  input  logic [3*COLOR_WIDTH-1:0] border_color_i,
  input  logic                     clr_status_i,
  vga_pixel_pipe_if.master         src_if,
  output logic [COLOR_WIDTH-1:0]   red_o,
  output logic [COLOR_WIDTH-1:0]   green_o,
  output logic [COLOR_WIDTH-1:0]   blue_o,
  output logic                     frame_start_o,
  output logic                     underflow_o,
  output logic [1:0]               mode_cur_o
);

  localparam int unsigned PixW = 3 * COLOR_WIDTH;

  logic                     at_origin;
  logic                     active;
  mode_e                    mode_eff;
  logic [REZ_MAX_WIDTH-1:0] xr;
  logic [REZ_MAX_WIDTH-1:0] yr;
  logic [PixW-1:0]          pat;

  mode_e           mode_cur_q;
  logic            origin_q;
  logic            active1_q;
  mode_e           mode1_q;
  logic            req_q;
  logic            frame1_q;
  logic [PixW-1:0] pat1_q;

  logic [PixW-1:0] rgb_d, rgb_q;
  logic            frame2_q;
  logic            uf_set;
  logic            underflow_q;

  assign at_origin = (count_h_i == '0) && (count_v_i == '0);
  assign active    = (count_h_i >= h_left_margin_i) && (count_h_i <= h_right_margin_i) &&
                     (count_v_i >= v_left_margin_i) && (count_v_i <= v_right_margin_i);

  // Pixel (0,0) already uses the newly requested mode.
  assign mode_eff  = at_origin ? mode_e'(mode_i) : mode_cur_q;

  assign xr = count_h_i - h_left_margin_i;
  assign yr = count_v_i - v_left_margin_i;

  vga_pattern_gen #(
    .COLOR_WIDTH   (COLOR_WIDTH),
    .REZ_MAX_WIDTH (REZ_MAX_WIDTH),
    .BAR_SHIFT     (BAR_SHIFT),
    .CHK_SHIFT     (CHK_SHIFT)
  ) u_pattern_gen (
    .xr_i    (xr),
    .yr_i    (yr),
    .mode_i  (mode_eff),
    .color_o (pat)
  );

  always_comb begin
    rgb_d  = '0;
    uf_set = 1'b0;
    if (!active1_q) begin
      if (mode1_q == ModeBorder) rgb_d = border_color_i;
    end else begin
      unique case (mode1_q)
        ModePass: begin
          if (src_if.data_valid) rgb_d = src_if.data;
          else                   uf_set = 1'b1;
        end
        ModeBars, ModeCheck: rgb_d = pat1_q;
        default:             rgb_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mode_cur_q  <= ModePass;
      origin_q    <= 1'b0;
      active1_q   <= 1'b0;
      mode1_q     <= ModePass;
      req_q       <= 1'b0;
      frame1_q    <= 1'b0;
      pat1_q      <= '0;
      rgb_q       <= '0;
      frame2_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mode_cur_q  <= mode_eff;
      origin_q    <= at_origin;
      active1_q   <= active;
      mode1_q     <= mode_eff;
      req_q       <= active && (mode_eff == ModePass);
      // Rising edge of the origin, so a dwell at (0,0) yields one pulse.
      frame1_q    <= at_origin && !origin_q;
      pat1_q      <= pat;
      rgb_q       <= rgb_d;
      frame2_q    <= frame1_q;
      underflow_q <= uf_set || (underflow_q && !clr_status_i);
    end
  end

  assign src_if.data_req = req_q;
  assign red_o           = rgb_q[COLOR_WIDTH-1:0];
  assign green_o         = rgb_q[2*COLOR_WIDTH-1:COLOR_WIDTH];
  assign blue_o          = rgb_q[3*COLOR_WIDTH-1:2*COLOR_WIDTH];
  assign frame_start_o   = frame2_q;
  assign underflow_o     = underflow_q;
  assign mode_cur_o      = mode_cur_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Randomised bench for vga_pixel_pipe against a cycle-level behavioural pixel model.
module tb_vga_pixel_pipe;

  localparam int CW        = 4;
  localparam int RW        = 11;
  localparam int BAR_SHIFT = 6;
  localparam int CHK_SHIFT = 5;
  localparam int BAR_W     = 1 << BAR_SHIFT;
  localparam int CHK_W     = 1 << CHK_SHIFT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] count_h = '0, count_v = '0;
  logic [RW-1:0] hl = '0, hr = '0, vl = '0, vr = '0;
  logic [1:0]    mode_in = '0;
  logic [11:0]   border_in = '0, data_in = '0;
  logic          valid_in = 1'b0, clr_in = 1'b0;
  logic [CW-1:0] red, green, blue;
  logic          frame_start, underflow;
  logic [1:0]    mode_cur;
  logic [11:0]   got_rgb;

  int n_checks = 0;
  int n_errors = 0;

  // Model: stage-1 view of the previous cycle plus frame-level state.
  logic m_act_p = 1'b0, m_frame_p = 1'b0, m_prev_origin = 1'b0, m_uf = 1'b0;
  int   m_mode_p = 0, m_xr_p = 0, m_yr_p = 0, m_mode = 0;
  // Expected outputs after the most recent clock edge.
  logic [11:0] exp_rgb = '0;
  logic        exp_req = 1'b0, exp_fs = 1'b0, exp_uf = 1'b0;
  logic [1:0]  exp_mode = '0;

  vga_pixel_pipe_if #(.COLOR_WIDTH(CW)) src_if ();

  assign src_if.data       = data_in;
  assign src_if.data_valid = valid_in;
  assign got_rgb           = {blue, green, red};

  vga_pixel_pipe #(
    .COLOR_WIDTH   (CW),
    .REZ_MAX_WIDTH (RW),
    .BAR_SHIFT     (BAR_SHIFT),
    .CHK_SHIFT     (CHK_SHIFT)
  ) dut (
    .clk_i            (clk),
    .rst_n            (rst_n),
    .count_h_i        (count_h),
    .count_v_i        (count_v),
    .h_left_margin_i  (hl),
    .h_right_margin_i (hr),
    .v_left_margin_i  (vl),
    .v_right_margin_i (vr),
    .mode_i           (mode_in),
    .border_color_i   (border_in),
    .clr_status_i     (clr_in),
    .src_if           (src_if),
    .red_o            (red),
    .green_o          (green),
    .blue_o           (blue),
    .frame_start_o    (frame_start),
    .underflow_o      (underflow),
    .mode_cur_o       (mode_cur)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Colour the display should show for one pixel, from the region/mode rules.
  function automatic logic [11:0] ref_pixel(input logic act, input int mode, input int xr,
                                            input int yr);
    int idx;
    if (!act) return (mode == 1) ? border_in : 12'h000;
    case (mode)
      0: return valid_in ? data_in : 12'h000;
      2: begin
        idx = (xr / BAR_W) % 8;
        return {((idx / 4) % 2 != 0) ? 4'hF : 4'h0, ((idx / 2) % 2 != 0) ? 4'hF : 4'h0,
                (idx % 2 != 0) ? 4'hF : 4'h0};
      end
      3: return (((xr / CHK_W) + (yr / CHK_W)) % 2 != 0) ? 12'hFFF : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  task automatic model_reset();
    m_act_p = 1'b0; m_frame_p = 1'b0; m_prev_origin = 1'b0; m_uf = 1'b0;
    m_mode_p = 0; m_xr_p = 0; m_yr_p = 0; m_mode = 0;
  endtask

  // Present counters (h,v) for one cycle, advance the model, step past the edge.
  task automatic tick(input int h, input int v);
    logic origin, act;
    int   eff;
    origin   = (h == 0) && (v == 0);
    eff      = origin ? int'(mode_in) : m_mode;
    act      = (h >= int'(hl)) && (h <= int'(hr)) && (v >= int'(vl)) && (v <= int'(vr));
    exp_rgb  = ref_pixel(m_act_p, m_mode_p, m_xr_p, m_yr_p);
    m_uf     = (m_act_p && m_mode_p == 0 && !valid_in) || (m_uf && !clr_in);
    exp_uf   = m_uf;
    exp_fs   = m_frame_p;
    exp_req  = act && (eff == 0);
    exp_mode = 2'(eff);
    m_frame_p     = origin && !m_prev_origin;
    m_prev_origin = origin;
    m_mode   = eff;
    m_act_p  = act;
    m_mode_p = eff;
    m_xr_p   = h - int'(hl);
    m_yr_p   = v - int'(vl);
    count_h  = RW'(h);
    count_v  = RW'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic set_vga_region();
    hl = 11'd144; hr = 11'd783; vl = 11'd35; vr = 11'd514;
  endtask

  task automatic test_reset();
    set_vga_region();
    mode_in = 2'd0; valid_in = 1'b1; clr_in = 1'b0; data_in = 12'h5A3;
    tick(0, 0);
    tick(200, 100);
    valid_in = 1'b0;
    tick(201, 100);
    valid_in = 1'b1;
    tick(202, 100);
    n_checks++;
    if (src_if.data_req !== exp_req || underflow !== exp_uf || got_rgb !== exp_rgb) begin
      n_errors++;
      $display("FAIL pre_reset got req=%b uf=%b rgb=%h want req=%b uf=%b rgb=%h",
               src_if.data_req, underflow, got_rgb, exp_req, exp_uf, exp_rgb);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (got_rgb !== 12'h000 || src_if.data_req !== 1'b0 || underflow !== 1'b0 ||
        frame_start !== 1'b0 || mode_cur !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_async got rgb=%h req=%b uf=%b fs=%b mode=%0d want all zero",
               got_rgb, src_if.data_req, underflow, frame_start, mode_cur);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    mode_in = 2'd3;
    tick(300, 300);
    n_checks++;
    if (mode_cur !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_mode_hold got %0d want 0", mode_cur);
    end
    mode_in = 2'd0;
    tick(0, 0);
    n_checks++;
    if (mode_cur !== 2'd0 || underflow !== 1'b0 || got_rgb !== exp_rgb) begin
      n_errors++;
      $display("FAIL reset_after got mode=%0d uf=%b rgb=%h want mode=0 uf=0 rgb=%h",
               mode_cur, underflow, got_rgb, exp_rgb);
    end
  endtask

  task automatic test_pass_line();
    int          reqs;
    logic [11:0] want;
    set_vga_region();
    mode_in = 2'd0; valid_in = 1'b1; clr_in = 1'b0; data_in = 12'hABC;
    tick(0, 0);
    reqs = 0;
    for (int h = 0; h < 802; h++) begin
      if (h < 800) tick(h, 100);
      else         tick(h - 800, 101);
      if (h < 800 && src_if.data_req) reqs++;
      n_checks++;
      if (got_rgb !== exp_rgb || src_if.data_req !== exp_req) begin
        n_errors++;
        $display("FAIL pass_pixel h=%0d got rgb=%h req=%b want rgb=%h req=%b",
                 h, got_rgb, src_if.data_req, exp_rgb, exp_req);
      end
      // Output now shown belongs to counter h-1.
      if (h == 144 || h == 145 || h == 784 || h == 785) begin
        want = (h == 145 || h == 784) ? 12'hABC : 12'h000;
        n_checks++;
        if (got_rgb !== want) begin
          n_errors++;
          $display("FAIL pass_edge h=%0d got %h want %h", h - 1, got_rgb, want);
        end
      end
    end
    n_checks++;
    if (reqs != 640) begin
      n_errors++;
      $display("FAIL pass_req_count got %0d want 640", reqs);
    end
  endtask

  task automatic test_border();
    int ph, pv, h, v;
    logic [11:0] want;
    set_vga_region();
    mode_in = 2'd1; border_in = 12'h00F; valid_in = 1'b1; data_in = 12'h777;
    tick(0, 0);
    ph = 0; pv = 0;
    for (int i = 0; i < 200; i++) begin
      h = $urandom_range(1, 1023);
      v = $urandom_range(0, 600);
      tick(h, v);
      want = (ph >= 144 && ph <= 783 && pv >= 35 && pv <= 514) ? 12'h000 : 12'h00F;
      n_checks++;
      if (got_rgb !== want || got_rgb !== exp_rgb || src_if.data_req !== 1'b0) begin
        n_errors++;
        $display("FAIL border_pixel (%0d,%0d) got rgb=%h req=%b want rgb=%h req=0",
                 ph, pv, got_rgb, src_if.data_req, want);
      end
      ph = h; pv = v;
    end
  endtask

  task automatic test_bars();
    int xr;
    set_vga_region();
    mode_in = 2'd2; border_in = 12'h00F;
    tick(0, 0);
    for (int h = 320; h < 700; h++) begin
      tick(h, 200);
      xr = h - 1 - 144;
      n_checks++;
      if (got_rgb !== exp_rgb) begin
        n_errors++;
        $display("FAIL bars_pixel xr=%0d got %h want %h", xr, got_rgb, exp_rgb);
      end
      if ((xr >= 192 && xr <= 255) || xr == 511 || xr == 512) begin
        n_checks++;
        if (got_rgb !== ((xr == 512) ? 12'h000 : (xr == 511) ? 12'hFFF : 12'h0FF)) begin
          n_errors++;
          $display("FAIL bars_fixed xr=%0d got %h", xr, got_rgb);
        end
      end
    end
  endtask

  task automatic test_mode_change();
    int fs_cnt;
    set_vga_region();
    mode_in = 2'd0; valid_in = 1'b1;
    tick(0, 0);
    tick(10, 10);
    mode_in = 2'd3;
    for (int i = 0; i < 5; i++) begin
      tick(100 + i, 100);
      n_checks++;
      if (mode_cur !== 2'd0) begin
        n_errors++;
        $display("FAIL mode_hold i=%0d got %0d want 0", i, mode_cur);
      end
    end
    fs_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) tick(0, 0);
      else       tick(173 + i, 35);
      if (frame_start) fs_cnt++;
      n_checks++;
      if (mode_cur !== 2'd3 || frame_start !== exp_fs) begin
        n_errors++;
        $display("FAIL mode_switch i=%0d got mode=%0d fs=%b want mode=3 fs=%b",
                 i, mode_cur, frame_start, exp_fs);
      end
    end
    n_checks++;
    if (got_rgb !== 12'hFFF) begin
      n_errors++;
      $display("FAIL checker_xr32 got %h want fff", got_rgb);
    end
    n_checks++;
    if (fs_cnt != 1) begin
      n_errors++;
      $display("FAIL frame_start_once got %0d pulses want 1", fs_cnt);
    end
  endtask

  task automatic test_underflow();
    set_vga_region();
    mode_in = 2'd0; valid_in = 1'b1; clr_in = 1'b0; data_in = 12'h123;
    tick(0, 0);
    tick(200, 100);
    valid_in = 1'b0;
    tick(201, 100);
    n_checks++;
    if (got_rgb !== 12'h000 || underflow !== 1'b1) begin
      n_errors++;
      $display("FAIL uf_set got rgb=%h uf=%b want rgb=000 uf=1", got_rgb, underflow);
    end
    valid_in = 1'b1;
    tick(202, 100);
    n_checks++;
    if (underflow !== 1'b1 || got_rgb !== 12'h123) begin
      n_errors++;
      $display("FAIL uf_sticky got rgb=%h uf=%b want rgb=123 uf=1", got_rgb, underflow);
    end
    valid_in = 1'b0; clr_in = 1'b1;
    tick(203, 100);
    n_checks++;
    if (underflow !== 1'b1) begin
      n_errors++;
      $display("FAIL uf_set_over_clr got %b want 1", underflow);
    end
    valid_in = 1'b1;
    tick(204, 100);
    n_checks++;
    if (underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL uf_clear got %b want 0", underflow);
    end
    clr_in = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        hl = RW'($urandom_range(0, 900));  hr = RW'($urandom_range(0, 1023));
        vl = RW'($urandom_range(0, 900));  vr = RW'($urandom_range(0, 1023));
      end
      mode_in   = 2'($urandom);
      border_in = 12'($urandom);
      data_in   = 12'($urandom);
      valid_in  = ($urandom_range(0, 9) != 0);
      clr_in    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) tick(0, 0);
      else tick($urandom_range(0, 1023), $urandom_range(0, 1023));
      n_checks++;
      if (got_rgb !== exp_rgb || src_if.data_req !== exp_req || frame_start !== exp_fs ||
          underflow !== exp_uf || mode_cur !== exp_mode) begin
        n_errors++;
        $display("FAIL random i=%0d got rgb=%h req=%b fs=%b uf=%b mode=%0d want rgb=%h req=%b fs=%b uf=%b mode=%0d",
                 i, got_rgb, src_if.data_req, frame_start, underflow, mode_cur,
                 exp_rgb, exp_req, exp_fs, exp_uf, exp_mode);
      end
    end
    clr_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_pass_line();
    test_border();
    test_bars();
    test_mode_change();
    test_underflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_pixel_pipe.md
# vga_pixel_pipe

Parametrised successor to the VGA colour-assignment stage: a two-stage pixel pipeline between the timing counters and VGA_Control. It decides the display region and issues a one-cycle-ahead pixel request to the frame source. It drives RGB from one of four frame-synchronous modes: pass-through, border fill, colour bars or checkerboard. It also flags source underflow.

## Interface
Parameters:
- COLOR_WIDTH, 4, bits per colour channel
- REZ_MAX_WIDTH, 11, width of Count_h/Count_v and all margins
- BAR_SHIFT, 6, log2 of colour-bar width in pixels
- CHK_SHIFT, 5, log2 of checkerboard square size

Ports:
- Clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- Count_h  in  REZ_MAX_WIDTH  horizontal pixel counter
- Count_v  in  REZ_MAX_WIDTH  vertical line counter
- H_left_margin, H_right_margin  in  REZ_MAX_WIDTH  inclusive horizontal display bounds
- V_left_margin, V_right_margin  in  REZ_MAX_WIDTH  inclusive vertical display bounds
- Mode  in  2  requested mode: 0 pass, 1 border, 2 bars, 3 checker
- Border_color  in  3*COLOR_WIDTH  colour outside display region in border mode
- Data  in  3*COLOR_WIDTH  pixel from source; R=[C-1:0], G=[2C-1:C], B=[3C-1:2C]
- Data_valid  in  1  Data valid; sampled in the cycle after Data_req
- Clr_status  in  1  clears Underflow
- Data_req  out  1  request one pixel from source
- Red, Green, Blue  out  COLOR_WIDTH each  colour to VGA_Control
- Frame_start  out  1  one-cycle pulse, aligned with the RGB of pixel (0,0)
- Underflow  out  1  sticky: pass-mode active pixel with Data_valid low
- Mode_cur  out  2  mode currently in effect

## Operation
- Stage 1 (registered on Clk):
  - Active1 = Count_h in [H_left,H_right] and Count_v in [V_left,V_right], inclusive, unsigned compare.
  - Data_req = Active1 and Mode_cur==0.
  - Stage 1 also registers the pattern colour and a frame flag (Count_h==0 and Count_v==0).
- Mode latch: Mode_cur loads Mode only in the cycle where Count_h==0 and Count_v==0. Mode changes mid-frame take effect at the next frame.
- Pattern colour, computed in stage 1:
  - Relative x: xr = Count_h - H_left_margin, REZ_MAX_WIDTH bits, wrap ignored because it is used only when active. Relative y: yr = Count_v - V_left_margin.
  - Bars: idx = xr[BAR_SHIFT+2:BAR_SHIFT]. Red is all-ones if idx[0], Green if idx[1], Blue if idx[2]; otherwise zero. Eight bars, repeating.
  - Checker: white (all-ones) if xr[CHK_SHIFT]^yr[CHK_SHIFT], else black.
- Stage 2 (registered), RGB selection:
  - Inactive, mode 1: Border_color.
  - Inactive, other modes: zero.
  - Active, mode 0: Data if Data_valid, else zero, and Underflow is set.
  - Active, mode 2/3: registered pattern colour.
- Underflow clears on Clr_status. Set has priority over a simultaneous clear.
- Data outside request cycles is ignored.
- Margins are sampled every cycle; no shadowing.
- If left margin > right margin, no pixel is active; outputs follow the inactive rule.

## Timing
- Latency: counters at cycle N → Data_req at N+1 → Data/Data_valid sampled at N+1 → RGB and Frame_start at N+2.
- Source contract: combinational or registered-ahead data presented in the same cycle Data_req is high.
- Reset values: Red/Green/Blue=0, Data_req=0, Frame_start=0, Underflow=0, Mode_cur=0, all pipeline registers 0.
- Reset mid-frame: outputs go to zero immediately (asynchronous). After release, the first valid output appears 2 cycles after the counters resume. Mode_cur stays 0 until the next frame start.
- Frame_start pulses exactly once per frame, even if the counters dwell at (0,0).

## Structure
- Shared package/include: COLOR_WIDTH, REZ_MAX_WIDTH, and mode encodings MODE_PASS=0, MODE_BORDER=1, MODE_BARS=2, MODE_CHECK=3.
- One sub-module: vga_pattern_gen (xr, yr, mode → pattern colour, combinational), instantiated in stage 1.

## Test plan
- Reset mid-frame: rst_n low while active in pass mode → RGB=0 and Data_req=0 at once. After release and counters at 0,0, Mode_cur=0 and Underflow=0.
- Pass mode, 640x480 region (H 144..783, V 35..514), Data=12'hABC, valid on request → Red=4'hC, Green=4'hB, Blue=4'hA at the 2-cycle-delayed position. Data_req is high for exactly 640 cycles per active line. Pixel at Count_h=143 is black; 144 and 783 are colour; 784 is black.
- Border mode, Border_color=12'h00F → all inactive pixels output Red=4'hF; active pixels are black.
- Bars, BAR_SHIFT=6 → bar index 3 (xr=192..255) gives Red=F, Green=F, Blue=0; xr=512 wraps to index 0 (black).
- Mode written 0→3 mid-frame → Mode_cur unchanged until Count_h=Count_v=0, then 3. The checker square at xr=32, yr=0 is white.
- Underflow: pass mode, Data_valid low for one active pixel → that pixel is black and Underflow=1. Clr_status in the same cycle as a new underflow keeps Underflow=1; a lone Clr_status clears it.
